// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble binary-to-BCD converter.
// One shift/add-3 iteration per clock; the result is registered and
// accompanied by a one-cycle done strobe.
// Optional feature macro: BIN_TO_BCD_AUTO_EN (auto-start on bin_in change).
module bin_to_bcd #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic              ovfs_q, ovfs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [BW-1:0]     scr_adj;
    logic              kick;

`ifdef BIN_TO_BCD_AUTO_EN
    logic [WIDTH-1:0]  last_q, last_d;

    // Auto-start whenever the input differs from the last accepted value
    always_comb begin
        kick = start || (bin_in != last_q);
    end
`else
    // Conversions begin only on an explicit start request
    always_comb begin
        kick = start;
    end
`endif

    // Add-3 correction applied to every scratch digit of 5 or more
    always_comb begin
        scr_adj = scr_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath computation for the converter FSM
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        ovfs_d  = ovfs_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef BIN_TO_BCD_AUTO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (kick) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    ovfs_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef BIN_TO_BCD_AUTO_EN
                    last_d  = bin_in;
`endif
                end
            end
            SHIFT: begin
                // Publishing happens on the edge after the last shift, so
                // the DONE state coincides with the done strobe and a start
                // seen alongside done is still rejected.
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = scr_q;
                    ovf_d   = ovfs_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    scr_d  = {scr_adj[BW-2:0], bin_q[WIDTH-1]};
                    bin_d  = {bin_q[WIDTH-2:0], 1'b0};
                    ovfs_d = ovfs_q | scr_adj[BW-1];
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            ovfs_q  <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BIN_TO_BCD_AUTO_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            ovfs_q  <= ovfs_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef BIN_TO_BCD_AUTO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: randomized and directed checks of bin_to_bcd against a
// decimal-arithmetic reference, for a 3-digit and a 2-digit instance.
module tb_bin_to_bcd;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy, done, ovf;
    logic [11:0] bcd_out;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd_out2;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] exp_bcd3;
    logic [7:0]  exp_bcd2;
    logic        exp_ovf3, exp_ovf2;

    bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
    );

    bin_to_bcd #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd_out2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    // Decimal digits of v, truncated to ndig digits, packed 4 bits each
    function automatic logic [31:0] ref_bcd(input int v, input int ndig);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < ndig; i++) begin
            r = r | (32'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One conversion; poke adds ignored start pulses mid-run and on done
    task automatic convert(input logic [7:0] v, input bit poke);
        int c;
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        check_val("busy_rise", 32'(busy), 32'd1);
        while (!done && c < 30) begin
            if (c == 2) begin
                check_val("hold_bcd", 32'(bcd_out), 32'(exp_bcd3));
                if (poke) begin
                    start  = 1'b1;
                    bin_in = v ^ 8'h5A;
                end
            end else if (c == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        exp_bcd3 = 12'(ref_bcd(int'(v), 3));
        exp_bcd2 = 8'(ref_bcd(int'(v), 2));
        exp_ovf3 = (int'(v) >= 1000);
        exp_ovf2 = (int'(v) >= 100);
        check_val("latency", 32'(c), 32'(W + 1));
        check_val("bcd3", 32'(bcd_out), 32'(exp_bcd3));
        check_val("ovf3", 32'(ovf), 32'(exp_ovf3));
        check_val("bcd2", 32'(bcd_out2), 32'(exp_bcd2));
        check_val("ovf2", 32'(ovf2), 32'(exp_ovf2));
        check_val("done2", 32'(done2), 32'd1);
        check_val("busy_at_done", 32'(busy), 32'd1);
        if (poke) begin
            start  = 1'b1;
            bin_in = v ^ 8'h5A;
        end
        @(negedge clk);
        start = 1'b0;
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("busy_fall", 32'(busy), 32'd0);
        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_val("no_queue_done", 32'(done), 32'd0);
                check_val("no_queue_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        int seen;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        exp_bcd3 = '0;
        exp_bcd2 = '0;
        exp_ovf3 = 1'b0;
        exp_ovf2 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_bcd", 32'(bcd_out), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        convert(8'd0, 1'b0);
        convert(8'd255, 1'b0);
        convert(8'd128, 1'b0);
        convert(8'd99, 1'b0);
        convert(8'd210, 1'b0);
        convert(8'd35, 1'b1);
        convert(8'd45, 1'b0);
        convert(8'd120, 1'b0);
        convert(8'd127, 1'b0);

        // Abort a conversion of 200 with reset sampled on the fourth edge
        @(negedge clk);
        bin_in = 8'd200;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_bcd", 32'(bcd_out), 32'd0);
        check_val("abort_ovf", 32'(ovf), 32'd0);
        exp_bcd3 = '0;
        exp_bcd2 = '0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check_val("abort_quiet", 32'(seen), 32'd0);

        for (int n = 0; n < 150; n++) begin
            convert(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
